cfg_ctrl_ufm_multi: RTL and testbench

CFG_CTRL_UFM_MULTI -- requirements
Module: cfg_ctrl_ufm_multi

---
 rtl/cfg_ctrl_ufm_multi.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_cfg_ctrl_ufm_multi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_ctrl_ufm_multi.sv
// cfg_ctrl_ufm_multi: boots WORDS 16-bit configuration words out of the UFM
// serial interface after reset or on request, and exposes them via a CSR window.
// Optional program/erase path: `define CFG_CTRL_UFM_PROGRAM_EN.
// The UFM PROGRAM pin is exported as 'prog' because 'program' is a reserved word.
// All UFM strobes are registered from the current state, so the pins trail the
// state register by one clock; arclk/drclk pulse in the low phase of clk so the
// data launched at the rising edge is settled when the UFM samples it.
module cfg_ctrl_ufm_multi #(
  parameter logic [4:0]  BASE_ADDR = 5'h0,
  parameter int unsigned WORDS     = 2,
  parameter int unsigned ADDR_BITS = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            csr_a,
  input  logic [7:0]            csr_di,
  input  logic                  csr_we,
  output logic [7:0]            csr_do,
  input  logic                  start,
  input  logic                  failsafe_mode,
  output logic                  done,
  output logic [16*WORDS-1:0]   cfg,
  output logic                  arclk,
  output logic                  ardin,
  output logic                  arshft,
  output logic                  drclk,
  output logic                  drdin,
  output logic                  drshft,
  output logic                  erase,
  output logic                  prog,
  input  logic                  busy,
  input  logic                  drdout
);

  localparam int unsigned CFG_W     = 16 * WORDS;
  localparam int unsigned SHIFT_MAX = (ADDR_BITS > 16) ? ADDR_BITS : 16;
  localparam int unsigned CNT_W     = $clog2(SHIFT_MAX + 1);
  localparam int unsigned IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(15);
  localparam logic [IDX_W-1:0] W_LAST    = IDX_W'(WORDS - 1);

`ifdef CFG_CTRL_UFM_PROGRAM_EN
  typedef enum logic [3:0] {
    BOOT_ADDR, BOOT_LOAD, BOOT_DATA, DONE,
    PG_ADDR, PG_DATA, PG_PULSE, ER_PULSE, WAIT_BUSY
  } state_e;
`else
  typedef enum logic [1:0] {
    BOOT_ADDR, BOOT_LOAD, BOOT_DATA, DONE
  } state_e;
`endif

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     w_q, w_d;
  logic [14:0]          sh_q, sh_d;
  logic [CFG_W-1:0]     cfg_q, cfg_d;
  logic                 done_q, done_d;
  logic                 arclk_en_q, arclk_en_d;
  logic                 ardin_q, ardin_d;
  logic                 drclk_en_q, drclk_en_d;
  logic                 drshft_q, drshft_d;

  logic [4:0]           off_c;
  logic                 din_c;
  logic [15:0]          word_c;
  logic [ADDR_BITS-1:0] addr_c;
  logic                 addr_bit_c;

`ifdef CFG_CTRL_UFM_PROGRAM_EN
  logic [15:0]          wdata_q, wdata_d;
  logic [7:0]           waddr_q, waddr_d;
  logic                 drdin_q, drdin_d;
  logic                 prog_q, prog_d;
  logic                 erase_q, erase_d;
  logic                 ctrl_wr_c;
  logic                 data_bit_c;
`endif

  assign off_c  = csr_a - BASE_ADDR;
  assign din_c  = failsafe_mode | drdout;
  assign word_c = {sh_q, din_c};

  // Serial address source: word index during boot, staged WADDR when programming
`ifdef CFG_CTRL_UFM_PROGRAM_EN
  assign addr_c     = (state_q == PG_ADDR) ? ADDR_BITS'(waddr_q) : ADDR_BITS'(w_q);
  assign data_bit_c = |(wdata_q & (16'(1) << (DATA_LAST - cnt_q)));
  assign ctrl_wr_c  = csr_we && (off_c == 5'd11) && (state_q == DONE);
`else
  assign addr_c     = ADDR_BITS'(w_q);
`endif
  assign addr_bit_c = |(addr_c & (ADDR_BITS'(1) << (ADDR_LAST - cnt_q)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT_ADDR;
    else        state_q <= state_d;
  end

  // Next-state, shift counters and config capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    sh_d    = sh_q;
    cfg_d   = cfg_q;
    case (state_q)
      BOOT_ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          cnt_d   = '0;
          state_d = BOOT_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BOOT_LOAD: begin
        cnt_d   = '0;
        state_d = BOOT_DATA;
      end
      BOOT_DATA: begin
        sh_d = word_c[14:0];
        if (cnt_q == DATA_LAST) begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (w_q == IDX_W'(i)) cfg_d[16*i +: 16] = word_c;
          end
          cnt_d = '0;
          if (w_q == W_LAST) begin
            w_d     = '0;
            state_d = DONE;
          end else begin
            w_d     = w_q + IDX_W'(1);
            state_d = BOOT_ADDR;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
`ifdef CFG_CTRL_UFM_PROGRAM_EN
        if (ctrl_wr_c && csr_di[1]) begin
          state_d = ER_PULSE;
        end else if (ctrl_wr_c && csr_di[0]) begin
          cnt_d   = '0;
          state_d = PG_ADDR;
        end else
`endif
        if (start) begin
          cnt_d   = '0;
          w_d     = '0;
          state_d = BOOT_ADDR;
        end
      end
`ifdef CFG_CTRL_UFM_PROGRAM_EN
      PG_ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          cnt_d   = '0;
          state_d = PG_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PG_DATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = PG_PULSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PG_PULSE, ER_PULSE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // First cycle is unconditional: busy only rises after the pulse lands
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else if (!busy) begin
          cnt_d   = '0;
          w_d     = '0;
          state_d = BOOT_ADDR;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        w_d     = '0;
        state_d = BOOT_ADDR;
      end
    endcase
  end

  // UFM strobe decode from the current state
  always_comb begin
    arclk_en_d = 1'b0;
    ardin_d    = 1'b0;
    drclk_en_d = 1'b0;
    drshft_d   = 1'b1;
    done_d     = (state_d == DONE);
`ifdef CFG_CTRL_UFM_PROGRAM_EN
    drdin_d    = 1'b0;
    prog_d     = 1'b0;
    erase_d    = 1'b0;
`endif
    case (state_q)
      BOOT_ADDR: begin
        arclk_en_d = 1'b1;
        ardin_d    = addr_bit_c;
      end
      BOOT_LOAD: begin
        drclk_en_d = 1'b1;
        drshft_d   = 1'b0;
      end
      BOOT_DATA: drclk_en_d = 1'b1;
`ifdef CFG_CTRL_UFM_PROGRAM_EN
      PG_ADDR: begin
        arclk_en_d = 1'b1;
        ardin_d    = addr_bit_c;
      end
      PG_DATA: begin
        drclk_en_d = 1'b1;
        drdin_d    = data_bit_c;
      end
      PG_PULSE: prog_d  = 1'b1;
      ER_PULSE: erase_d = 1'b1;
`endif
      default: ;
    endcase
  end

  // Counters, captured config and registered UFM strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      w_q        <= '0;
      sh_q       <= '0;
      cfg_q      <= '0;
      done_q     <= 1'b0;
      arclk_en_q <= 1'b0;
      ardin_q    <= 1'b0;
      drclk_en_q <= 1'b0;
      drshft_q   <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      w_q        <= w_d;
      sh_q       <= sh_d;
      cfg_q      <= cfg_d;
      done_q     <= done_d;
      arclk_en_q <= arclk_en_d;
      ardin_q    <= ardin_d;
      drclk_en_q <= drclk_en_d;
      drshft_q   <= drshft_d;
    end
  end

`ifdef CFG_CTRL_UFM_PROGRAM_EN
  // Staging register writes, accepted in any state
  always_comb begin
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    if (csr_we) begin
      case (off_c)
        5'd8:    wdata_d[15:8] = csr_di;
        5'd9:    wdata_d[7:0]  = csr_di;
        5'd10:   waddr_d       = csr_di;
        default: ;
      endcase
    end
  end

  // Staging registers and program/erase strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q <= '0;
      waddr_q <= '0;
      drdin_q <= 1'b0;
      prog_q  <= 1'b0;
      erase_q <= 1'b0;
    end else begin
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      drdin_q <= drdin_d;
      prog_q  <= prog_d;
      erase_q <= erase_d;
    end
  end

  assign drdin = drdin_q;
  assign prog  = prog_q;
  assign erase = erase_q;
`else
  logic unused_csr_wr;
  assign unused_csr_wr = ^{csr_di, csr_we};
  assign drdin = 1'b0;
  assign prog  = 1'b0;
  assign erase = 1'b0;
`endif

  // CSR read mux
  always_comb begin
    csr_do = 8'h00;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (off_c == 5'(2 * i))     csr_do = cfg_q[16*i+8 +: 8];
      if (off_c == 5'(2 * i + 1)) csr_do = cfg_q[16*i +: 8];
    end
    if (off_c == 5'd11) csr_do = {~done_q, busy, 6'b0};
`ifdef CFG_CTRL_UFM_PROGRAM_EN
    if (off_c == 5'd8)  csr_do = wdata_q[15:8];
    if (off_c == 5'd9)  csr_do = wdata_q[7:0];
    if (off_c == 5'd10) csr_do = waddr_q;
`endif
  end

  assign arclk  = arclk_en_q & ~clk;
  assign drclk  = drclk_en_q & ~clk;
  assign ardin  = ardin_q;
  assign arshft = 1'b1;
  assign drshft = drshft_q;
  assign done   = done_q;
  assign cfg    = cfg_q;

endmodule

// File: tb/tb_cfg_ctrl_ufm_multi.sv
// Directed bench for cfg_ctrl_ufm_multi with a behavioural UFM model.
// Covers the program/erase path when CFG_CTRL_UFM_PROGRAM_EN is defined.
module tb_cfg_ctrl_ufm_multi;

  localparam int unsigned WORDS     = 2;
  localparam int unsigned ADDR_BITS = 9;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic csr_we;
  logic [7:0] csr_do;
  logic start, failsafe_mode, done;
  logic [16*WORDS-1:0] cfg;
  logic arclk, ardin, arshft, drclk, drdin, drshft, erase, prog;
  logic busy, drdout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_ctr = 0;

  always #5 clk = ~clk;

  cfg_ctrl_ufm_multi #(.BASE_ADDR(5'h0), .WORDS(WORDS), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we), .csr_do(csr_do),
    .start(start), .failsafe_mode(failsafe_mode), .done(done), .cfg(cfg),
    .arclk(arclk), .ardin(ardin), .arshft(arshft),
    .drclk(drclk), .drdin(drdin), .drshft(drshft),
    .erase(erase), .prog(prog), .busy(busy), .drdout(drdout)
  );

  // Behavioural UFM: address/data shift registers, 4-word array, 5-cycle busy
  logic [ADDR_BITS-1:0] areg = '0;
  logic [15:0] dreg = '0;
  logic [15:0] mem [0:3] = '{16'hA55A, 16'h1234, 16'h0000, 16'h0000};
  int busy_cnt = 0;
  logic force_busy = 1'b0;

  assign drdout = dreg[15];
  assign busy   = (busy_cnt != 0) | force_busy;

  always @(posedge arclk) if (arshft) areg <= {areg[ADDR_BITS-2:0], ardin};

  always @(posedge drclk) begin
    if (!drshft) dreg <= mem[areg[1:0]];
    else         dreg <= {dreg[14:0], drdin};
  end

  always @(posedge clk) begin
    if (erase) begin
      for (int i = 0; i < 4; i++) mem[i] <= 16'hFFFF;
    end else if (prog) begin
      mem[areg[1:0]] <= dreg;
    end
    if (prog || erase)      busy_cnt <= 5;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Pulse monitors
  logic mon_clr = 1'b0;
  int prog_cyc = 0;
  int erase_cyc = 0;
  always @(posedge clk) begin
    cyc_ctr <= cyc_ctr + 1;
    if (mon_clr) begin
      prog_cyc  <= 0;
      erase_cyc <= 0;
    end else begin
      if (prog)  prog_cyc  <= prog_cyc + 1;
      if (erase) erase_cyc <= erase_cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    chk(tag, 32'(csr_do), 32'(exp));
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic clr_mon();
    @(negedge clk); mon_clr = 1'b1;
    @(negedge clk); mon_clr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output int cyc);
    int t0;
    t0 = cyc_ctr;
    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      @(posedge clk); #1;
      cyc = cyc_ctr - t0;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int cyc, t0, bad, seen;
    rst_n = 1'b0; csr_a = '0; csr_di = '0; csr_we = 1'b0;
    start = 1'b0; failsafe_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg", cfg, 32'h0);
    chk("rst_strobes", 32'({arclk, drclk, arshft, drshft, prog, erase}), 32'b001100);
    chk_rd("rst_ctrl", 5'd11, 8'h80);

    // Boot after reset release
    @(negedge clk); rst_n = 1'b1;
    t0 = cyc_ctr;
    wait_done("boot_done", 100, cyc);
    cyc = cyc_ctr - t0;
    n_tests++;
    assert (cyc >= 52 && cyc <= 54) else begin
      n_fail++;
      $error("FAIL boot_latency: observed %0d expected 52..54", cyc);
    end
    chk("boot_cfg", cfg, 32'h1234_A55A);
    chk_rd("rd_off0", 5'd0, 8'hA5);
    chk_rd("rd_off1", 5'd1, 8'h5A);
    chk_rd("rd_off2", 5'd2, 8'h12);
    chk_rd("rd_off3", 5'd3, 8'h34);
    chk_rd("rd_unmapped4", 5'd4, 8'h00);
    chk_rd("rd_unmapped12", 5'd12, 8'h00);
    chk_rd("rd_ctrl_idle", 5'd11, 8'h00);
    force_busy = 1'b1;
    chk_rd("rd_ctrl_busy", 5'd11, 8'h40);
    force_busy = 1'b0;

    // Failsafe boot; cfg may only change at word boundaries
    failsafe_mode = 1'b1;
    start_pulse();
    #1;
    chk("start_clears_done", 32'(done), 32'd0);
    bad = 0;
    for (int k = 0; k < 100 && done !== 1'b1; k++) begin
      @(posedge clk); #1;
      if (!(cfg === 32'h1234_A55A || cfg === 32'h1234_FFFF || cfg === 32'hFFFF_FFFF)) bad++;
    end
    chk("failsafe_done", 32'(done), 32'd1);
    chk("cfg_word_atomic", 32'(bad), 32'd0);
    chk("failsafe_cfg", cfg, 32'hFFFF_FFFF);
    failsafe_mode = 1'b0;

    // Normal reboot; a second start mid-boot must not restart it
    @(negedge clk); start = 1'b1;
    @(posedge clk); t0 = cyc_ctr;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    start_pulse();
    wait_done("reboot_done", 100, cyc);
    cyc = cyc_ctr - t0 + 1;
    n_tests++;
    assert (cyc >= 52 && cyc <= 54) else begin
      n_fail++;
      $error("FAIL start_ignored_boot: observed %0d expected 52..54", cyc);
    end
    chk("reboot_cfg", cfg, 32'h1234_A55A);

`ifdef CFG_CTRL_UFM_PROGRAM_EN
    // Program word 1 with BEEF
    wr(5'd10, 8'h01);
    wr(5'd8, 8'hBE);
    wr(5'd9, 8'hEF);
    chk_rd("rd_wdata_hi", 5'd8, 8'hBE);
    chk_rd("rd_wdata_lo", 5'd9, 8'hEF);
    chk_rd("rd_waddr", 5'd10, 8'h01);
    clr_mon();
    wr(5'd11, 8'h01);
    #1;
    chk("pg_leaves_done", 32'(done), 32'd0);
    wait_done("pg_done", 300, cyc);
    chk("pg_prog_pulses", 32'(prog_cyc), 32'd1);
    chk("pg_erase_pulses", 32'(erase_cyc), 32'd0);
    chk("pg_cfg", cfg, 32'hBEEF_A55A);
    chk_rd("pg_rd_off2", 5'd2, 8'hBE);

    // Erase wins over program; start during WAIT_BUSY is ignored
    clr_mon();
    wr(5'd11, 8'h03);
    for (int k = 0; k < 20 && erase !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    chk("er_pulse_seen", 32'(erase), 32'd1);
    start_pulse();
    bad = 0; seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (busy) seen++;
      if (busy && (arclk || drclk)) bad++;
    end
    chk("er_busy_seen", 32'(seen != 0), 32'd1);
    chk("er_start_ignored", 32'(bad), 32'd0);
    wait_done("er_done", 300, cyc);
    chk("er_erase_pulses", 32'(erase_cyc), 32'd1);
    chk("er_prog_pulses", 32'(prog_cyc), 32'd0);
    chk("er_cfg", cfg, 32'hFFFF_FFFF);

    // Reset during PG_DATA aborts programming
    wr(5'd10, 8'h00);
    wr(5'd8, 8'h00);
    wr(5'd9, 8'h00);
    clr_mon();
    wr(5'd11, 8'h01);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", 32'({prog, erase, done, arclk, drclk}), 32'b0);
    chk("abort_cfg", cfg, 32'h0);
    chk_rd("abort_wdata", 5'd8, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    wait_done("abort_reboot", 300, cyc);
    chk("abort_prog_pulses", 32'(prog_cyc), 32'd0);
    chk("abort_cfg_after", cfg, 32'hFFFF_FFFF);
`else
    // Program path absent: staging unwritten, CTRL ignored
    wr(5'd8, 8'hBE);
    wr(5'd9, 8'hEF);
    wr(5'd10, 8'h01);
    chk_rd("rd_off8_absent", 5'd8, 8'h00);
    chk_rd("rd_off9_absent", 5'd9, 8'h00);
    chk_rd("rd_off10_absent", 5'd10, 8'h00);
    clr_mon();
    wr(5'd11, 8'h01);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done !== 1'b1 || arclk || drclk) bad++;
    end
    chk("ctrl_ignored", 32'(bad), 32'd0);
    chk("ctrl_no_prog", 32'(prog_cyc + erase_cyc), 32'd0);
    chk("ctrl_cfg_kept", cfg, 32'h1234_A55A);
    force_busy = 1'b1;
    chk_rd("rd_ctrl_busy2", 5'd11, 8'h40);
    force_busy = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
